twelve_state_monitor: RTL and testbench
=======================================

TWELVE_STATE_MONITOR -- requirements
Module: twelve_state_monitor

Interface
REQ-001 The block SHALL have one parameter: WRAP_W, default 8, the width of the wrap counter.
REQ-002 The block SHALL have port clk, input, 1 bit: the clock, shared with the upstream twelve-state counter.
REQ-003 The block SHALL have port rstb, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port cnt_en, input, 1 bit: a copy of the counter's count enable.
REQ-005 The block SHALL have port count, input, 4 bits: the counter state.
REQ-006 The block SHALL have port clr, input, 1 bit: synchronous clear of the sticky error and the wrap counter.
REQ-007 The block SHALL have port idx, output, 4 bits: the registered position 0..11 of count in the sequence.
REQ-008 The block SHALL have port idx_vld, output, 1 bit: idx is meaningful.
REQ-009 The block SHALL have port wrap, output, 1 bit: a one-cycle pulse on each completed 12-state cycle.
REQ-010 The block SHALL have port wrap_cnt, output, WRAP_W bits: the saturating count of wraps.
REQ-011 The block SHALL have port err, output, 1 bit: sticky sequence-violation flag.
REQ-012 The block SHALL have port err_code, output, 2 bits: code of the first violation.

Function
REQ-013 The legal sequence SHALL be SEQ[0..11] = 4'h0..4'hB, defined in the package; 4'hF SHALL be the IDLE code, which is the counter's reset value.
REQ-014 Each clock, the block SHALL register prev_count <= count and prev_en <= cnt_en.
REQ-015 The expected count SHALL be: prev_en ? succ(prev_count) : prev_count, where succ(SEQ[i]) = SEQ[(i+1) mod 12] and succ(4'hF) = SEQ[0].
REQ-016 The FSM SHALL have three states: IDLE, RUN and FAULT.
REQ-017 In IDLE, count == 4'hF SHALL keep the FSM in IDLE; count == SEQ[0] with prev_en=1 SHALL move it to RUN; any other value SHALL move it to FAULT.
REQ-018 In RUN, count == expected SHALL keep the FSM in RUN; any other value SHALL move it to FAULT.
REQ-019 FAULT SHALL be exited only by rstb, or by clr when count == 4'hF, which returns the FSM to IDLE.
REQ-020 err_code SHALL be 01 for a code outside SEQ and not 4'hF, 10 for a legal code that is not the expected one, and 11 for 4'hF seen while in RUN.
REQ-021 When several codes apply in the same cycle, the lowest nonzero code SHALL win.
REQ-022 err and err_code SHALL be registered, asserting in the cycle after the offending count is sampled; err_code SHALL hold the first violation until cleared.
REQ-023 wrap SHALL pulse for exactly one cycle, one cycle after a RUN-state step SEQ[11]->SEQ[0] with prev_en=1.
REQ-024 wrap_cnt SHALL increment on each wrap and saturate at all-ones.
REQ-025 idx SHALL equal the position of count, registered with one-cycle latency; idx_vld SHALL be 1 only in RUN with a legal code, otherwise idx SHALL be 0.
REQ-026 When clr and wrap occur in the same cycle, clr SHALL win: wrap_cnt becomes 0 and wrap still pulses.
REQ-027 When clr and a new violation occur in the same cycle, the violation SHALL win: err=1 with its code.
REQ-028 The FSM SHALL never stall; no input handshake exists.

Reset
REQ-029 rstb low SHALL asynchronously set: FSM=IDLE, prev_count=4'hF, prev_en=0, idx=0, idx_vld=0, wrap=0, wrap_cnt=0, err=0, err_code=00.
REQ-030 Reset asserted mid-cycle SHALL abort any pending wrap or error pulse with no glitch after release.
REQ-031 The first clock edge after rstb release SHALL evaluate against prev_count=4'hF.

Structure
REQ-032 The shared package SHALL hold the IDLE code, the SEQ table, the error-code constants and the FSM state type.
REQ-033 The block SHALL contain one sub-module, seq_lookup, which is combinational: count in, legal/idx/succ out.
REQ-034 All sequential elements SHALL be in the top-level module.

Verification
REQ-035 Reset, then cnt_en=1 for 13 cycles with a correct counter model: idx runs 0..11, wrap=1 once, wrap_cnt=1, err=0.
REQ-036 Hold cnt_en=0 at count=4'h5 for 4 cycles: idx stays 5, no err.
REQ-037 Force count=4'hC in RUN: err=1 and err_code=01 one cycle later; a later count=4'h3 leaves err_code at 01.
REQ-038 prev_count=4'h4 with prev_en=1 but count=4'h6: err_code=10; then clr with count=4'hF: err=0 and FSM returns to IDLE.
REQ-039 Run 260 wraps with WRAP_W=8: wrap_cnt saturates at 255; clr coincident with a wrap gives wrap_cnt=0 and wrap=1.
REQ-040 Assert rstb low mid-sequence at count=4'h7: all outputs take their reset values immediately and the sequence restarts from 4'hF->4'h0 with no error.

Source files
------------

// File: rtl/twelve_state_monitor_pkg.sv
// Shared definitions for the twelve-state counter monitor: codes, sequence table,
// error codes and FSM state type.
`timescale 1ns/1ps
package twelve_state_monitor_pkg;

  localparam int unsigned SEQ_LEN = 12;
  localparam int unsigned CODE_W  = 4;
  localparam int unsigned ERR_W   = 2;

  localparam logic [CODE_W-1:0] IDLE_CODE = 4'hF;

  localparam logic [CODE_W-1:0] SEQ [SEQ_LEN] = '{
    4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5,
    4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB
  };

  localparam logic [ERR_W-1:0] ERR_NONE    = 2'b00;
  localparam logic [ERR_W-1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [ERR_W-1:0] ERR_ORDER   = 2'b10;
  localparam logic [ERR_W-1:0] ERR_IDLE    = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

endpackage

// File: rtl/twelve_state_monitor_seq_lookup.sv
// Combinational decode of a counter code: legality, sequence position and successor.
`timescale 1ns/1ps
module seq_lookup
  import twelve_state_monitor_pkg::*;
(
  input  logic [3:0] count,
  output logic       legal,
  output logic [3:0] idx,
  output logic [3:0] succ
);

  // Codes outside the table (including IDLE) step to SEQ[0].
  always_comb begin
    legal = 1'b0;
    idx   = 4'h0;
    succ  = SEQ[0];
    for (int unsigned i = 0; i < SEQ_LEN; i++) begin
      if (count == SEQ[i]) begin
        legal = 1'b1;
        idx   = 4'(i);
        succ  = SEQ[(i + 1) % SEQ_LEN];
      end
    end
  end

endmodule

// File: rtl/twelve_state_monitor.sv
// Checks an upstream twelve-state counter against its legal sequence; reports
// position, wraps and the first sequence violation.
`timescale 1ns/1ps
module twelve_state_monitor
  import twelve_state_monitor_pkg::*;
#(
  parameter int unsigned WRAP_W = 8
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              cnt_en,
  input  logic [3:0]        count,
  input  logic              clr,
  output logic [3:0]        idx,
  output logic              idx_vld,
  output logic              wrap,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic              err,
  output logic [1:0]        err_code
);

  state_t            state;
  state_t            state_nxt;
  logic [3:0]        prev_count;
  logic [3:0]        prev_succ;
  logic              prev_en;
  logic              lk_legal;
  logic [3:0]        lk_idx;
  logic [3:0]        lk_succ;
  logic [3:0]        expected;
  logic [ERR_W-1:0]  viol_code;
  logic              wrap_step;
  logic              run_legal;

  seq_lookup u_lookup (
    .count (count),
    .legal (lk_legal),
    .idx   (lk_idx),
    .succ  (lk_succ)
  );

  // Successor of prev_count is captured alongside it so one lookup suffices.
  assign expected  = prev_en ? prev_succ : prev_count;
  assign run_legal = (state_nxt == ST_RUN) && lk_legal;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    viol_code = ERR_NONE;
    wrap_step = 1'b0;
    case (state)
      ST_IDLE: begin
        if (count == IDLE_CODE) begin
          state_nxt = ST_IDLE;
        end else if (count == SEQ[0] && prev_en) begin
          state_nxt = ST_RUN;
        end else begin
          state_nxt = ST_FAULT;
          viol_code = lk_legal ? ERR_ORDER : ERR_ILLEGAL;
        end
      end
      ST_RUN: begin
        if (count == expected) begin
          wrap_step = prev_en && (prev_count == SEQ[SEQ_LEN-1]) && (count == SEQ[0]);
        end else begin
          state_nxt = ST_FAULT;
          if (!lk_legal && count != IDLE_CODE) viol_code = ERR_ILLEGAL;
          else if (lk_legal)                   viol_code = ERR_ORDER;
          else                                 viol_code = ERR_IDLE;
        end
      end
      ST_FAULT: begin
        if (clr && count == IDLE_CODE) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // A violation takes priority over clr in the same cycle.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      prev_count <= IDLE_CODE;
      prev_succ  <= SEQ[0];
      prev_en    <= 1'b0;
      idx        <= 4'h0;
      idx_vld    <= 1'b0;
      wrap       <= 1'b0;
      wrap_cnt   <= '0;
      err        <= 1'b0;
      err_code   <= ERR_NONE;
    end else begin
      prev_count <= count;
      prev_succ  <= lk_succ;
      prev_en    <= cnt_en;
      idx_vld    <= run_legal;
      idx        <= run_legal ? lk_idx : 4'h0;
      wrap       <= wrap_step;
      if (clr)                                wrap_cnt <= '0;
      else if (wrap_step && wrap_cnt != '1)   wrap_cnt <= wrap_cnt + WRAP_W'(1);
      if (viol_code != ERR_NONE) begin
        err      <= 1'b1;
        err_code <= viol_code;
      end else if (clr) begin
        err      <= 1'b0;
        err_code <= ERR_NONE;
      end
    end
  end

endmodule

// File: tb/tb_twelve_state_monitor.sv
// Scoreboard bench for twelve_state_monitor: directed scenarios plus random
// counter traffic against a behavioural model.
`timescale 1ns/1ps
module tb_twelve_state_monitor;

  logic       clk = 1'b0;
  logic       rstb;
  logic       cnt_en;
  logic [3:0] count;
  logic       clr;
  logic [3:0] idx;
  logic       idx_vld;
  logic       wrap;
  logic [7:0] wrap_cnt;
  logic       err;
  logic [1:0] err_code;

  twelve_state_monitor #(.WRAP_W(8)) dut (
    .clk      (clk),
    .rstb     (rstb),
    .cnt_en   (cnt_en),
    .count    (count),
    .clr      (clr),
    .idx      (idx),
    .idx_vld  (idx_vld),
    .wrap     (wrap),
    .wrap_cnt (wrap_cnt),
    .err      (err),
    .err_code (err_code)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] idx;
    logic       vld;
    logic       wrap;
    logic [7:0] wcnt;
    logic       err;
    logic [1:0] code;
  } obs_t;

  obs_t  exp_q[$];
  string name_q[$];
  string phase = "init";
  int    checks = 0;
  int    failures = 0;

  // Reference model state: mode 0 = waiting, 1 = tracking, 2 = faulted.
  int m_prev, m_mode, m_code, m_wcnt, m_idx;
  bit m_pen, m_err, m_wrap, m_vld;
  int ctr;

  function automatic int succ_of(int c);
    return (c == 15) ? 0 : ((c + 1) % 12);
  endfunction

  function automatic bit is_legal(int c);
    return (c >= 0) && (c < 12);
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    o.idx  = 4'(m_idx);
    o.vld  = m_vld;
    o.wrap = m_wrap;
    o.wcnt = 8'(m_wcnt);
    o.err  = m_err;
    o.code = 2'(m_code);
    return o;
  endfunction

  function automatic obs_t dut_obs();
    obs_t o;
    o.idx  = idx;
    o.vld  = idx_vld;
    o.wrap = wrap;
    o.wcnt = wrap_cnt;
    o.err  = err;
    o.code = err_code;
    return o;
  endfunction

  task automatic model_reset();
    m_prev = 15; m_pen = 1'b0; m_mode = 0; m_err = 1'b0; m_code = 0;
    m_wcnt = 0; m_wrap = 1'b0; m_vld = 1'b0; m_idx = 0;
  endtask

  task automatic model_step(int c, bit en, bit cl);
    int exp_c = m_pen ? succ_of(m_prev) : m_prev;
    int nxt = m_mode;
    int code = 0;
    bit wr = 1'b0;
    case (m_mode)
      0: begin
        if (c == 15) nxt = 0;
        else if (c == 0 && m_pen) nxt = 1;
        else begin nxt = 2; code = is_legal(c) ? 2 : 1; end
      end
      1: begin
        if (c == exp_c) wr = (m_prev == 11) && m_pen && (c == 0);
        else begin nxt = 2; code = (c == 15) ? 3 : (is_legal(c) ? 2 : 1); end
      end
      default: if (cl && c == 15) nxt = 0;
    endcase
    if (code != 0) begin m_err = 1'b1; m_code = code; end
    else if (cl) begin m_err = 1'b0; m_code = 0; end
    if (cl) m_wcnt = 0;
    else if (wr && m_wcnt < 255) m_wcnt = m_wcnt + 1;
    m_wrap = wr;
    m_vld  = (nxt == 1) && is_legal(c);
    m_idx  = m_vld ? c : 0;
    m_prev = c; m_pen = en; m_mode = nxt;
    exp_q.push_back(model_obs());
    name_q.push_back(phase);
  endtask

  task automatic check(string nm, obs_t act, obs_t want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s @%0t: got idx=%0d vld=%0b wrap=%0b wcnt=%0d err=%0b code=%0d, expected idx=%0d vld=%0b wrap=%0b wcnt=%0d err=%0b code=%0d",
               nm, $time, act.idx, act.vld, act.wrap, act.wcnt, act.err, act.code,
               want.idx, want.vld, want.wrap, want.wcnt, want.err, want.code);
    end
  endtask

  task automatic cyc(int c, bit en, bit cl);
    @(negedge clk);
    count = 4'(c); cnt_en = en; clr = cl;
    model_step(c, en, cl);
  endtask

  task automatic drive_ctr(bit en, bit cl);
    cyc(ctr, en, cl);
    if (en) ctr = succ_of(ctr);
  endtask

  // Release reset at a falling edge with the counter at IDLE.
  task automatic release_reset();
    @(negedge clk);
    rstb = 1'b1;
    count = 4'hF; cnt_en = 1'b0; clr = 1'b0;
    model_step(15, 1'b0, 1'b0);
    ctr = 15;
  endtask

  // Monitor: one expected observation per active clock edge.
  always @(posedge clk) begin
    #1;
    if (rstb && exp_q.size() > 0) check(name_q.pop_front(), dut_obs(), exp_q.pop_front());
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation exceeded time limit, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    rstb = 1'b0; count = 4'hF; cnt_en = 1'b0; clr = 1'b0;
    model_reset();
    ctr = 15;
    #3;
    check("reset_values", dut_obs(), model_obs());
    repeat (2) @(negedge clk);
    release_reset();

    phase = "count_13";
    repeat (14) drive_ctr(1'b1, 1'b0);

    phase = "hold_5";
    while (ctr != 5) drive_ctr(1'b1, 1'b0);
    repeat (4) drive_ctr(1'b0, 1'b0);

    phase = "illegal_C";
    drive_ctr(1'b1, 1'b0);
    cyc(12, 1'b1, 1'b0);
    cyc(3, 1'b1, 1'b0);
    cyc(3, 1'b0, 1'b0);
    phase = "clear_1";
    cyc(15, 1'b0, 1'b1);
    ctr = 15;

    phase = "skip_4_6";
    while (ctr != 5) drive_ctr(1'b1, 1'b0);
    cyc(6, 1'b1, 1'b0);
    cyc(7, 1'b1, 1'b0);
    phase = "clear_2";
    cyc(15, 1'b0, 1'b1);
    ctr = 15;
    repeat (3) drive_ctr(1'b1, 1'b0);

    phase = "saturate";
    for (int k = 0; k < 4000 && m_wcnt < 255; k++) drive_ctr(1'b1, 1'b0);
    repeat (60) drive_ctr(1'b1, 1'b0);
    phase = "clr_on_wrap";
    for (int k = 0; k < 12 && ctr != 0; k++) drive_ctr(1'b1, 1'b0);
    drive_ctr(1'b1, 1'b1);
    repeat (3) drive_ctr(1'b1, 1'b0);

    phase = "mid_reset";
    while (ctr != 7) drive_ctr(1'b1, 1'b0);
    drive_ctr(1'b1, 1'b0);
    #2;
    rstb = 1'b0;
    exp_q.delete();
    name_q.delete();
    model_reset();
    #1;
    check("async_reset", dut_obs(), model_obs());
    repeat (2) @(negedge clk);
    release_reset();
    phase = "restart";
    repeat (16) drive_ctr(1'b1, 1'b0);

    phase = "random";
    for (int k = 0; k < 800; k++) begin
      int r = int'($urandom_range(0, 99));
      if (m_mode == 2) begin
        if (r < 40) begin cyc(15, 1'b0, 1'b1); ctr = 15; end
        else cyc(int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b0);
      end else if (r < 3) begin
        cyc(int'($urandom_range(0, 15)), 1'b1, 1'b0);
      end else if (r < 6) begin
        drive_ctr(1'($urandom_range(0, 1)), 1'b1);
      end else begin
        drive_ctr(1'($urandom_range(0, 3) != 0), 1'b0);
      end
    end

    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expected observations left, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
